// File: rtl/regfile_port_arbiter_if.sv
// Bus bundle between two requesters, the shared register file and the port arbiter.
// master: requester/register-file side; slave: the arbiter.
interface regfile_port_arbiter_if;
    logic        req_a;
    logic        we_a;
    logic [4:0]  dr_a;
    logic [4:0]  sr1_a;
    logic [4:0]  sr2_a;
    logic [31:0] wd_a;
    logic        gnt_a;

    logic        req_b;
    logic        we_b;
    logic [4:0]  dr_b;
    logic [4:0]  sr1_b;
    logic [4:0]  sr2_b;
    logic [31:0] wd_b;
    logic        lock_b;
    logic        gnt_b;

    logic        RegW;
    logic [4:0]  DR;
    logic [4:0]  SR1;
    logic [4:0]  SR2;
    logic [31:0] Reg_In;
    logic [31:0] ReadReg1;
    logic [31:0] ReadReg2;

    logic        rvalid_a;
    logic        rvalid_b;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    modport master (
        output req_a, we_a, dr_a, sr1_a, sr2_a, wd_a,
        output req_b, we_b, dr_b, sr1_b, sr2_b, wd_b, lock_b,
        output ReadReg1, ReadReg2,
        input  gnt_a, gnt_b, RegW, DR, SR1, SR2, Reg_In,
        input  rvalid_a, rvalid_b, rdata1, rdata2
    );

    modport slave (
        input  req_a, we_a, dr_a, sr1_a, sr2_a, wd_a,
        input  req_b, we_b, dr_b, sr1_b, sr2_b, wd_b, lock_b,
        input  ReadReg1, ReadReg2,
        output gnt_a, gnt_b, RegW, DR, SR1, SR2, Reg_In,
        output rvalid_a, rvalid_b, rdata1, rdata2
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Arbitrates one register-file transaction per cycle between requester A (priority) and B,
// with B anti-starvation, locked B bursts, write-first read forwarding and r0 protection.
module regfile_port_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter bit          ZERO_R0   = 1'b1
) (
    input logic                   CLK,
    input logic                   RST_N,
    regfile_port_arbiter_if.slave bus
);
    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WaitMax  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);

    typedef enum logic [0:0] {StArb, StBurst} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          gnt_a, gnt_b;

    logic        sel_we;
    logic [4:0]  sel_dr, sel_sr1, sel_sr2;
    logic [31:0] sel_wd;
    logic        reg_w;

    logic        rvalid_a_q, rvalid_b_q;
    logic        fwd_we_q;
    logic [4:0]  fwd_dr_q, fwd_sr1_q, fwd_sr2_q;
    logic [31:0] fwd_wd_q;
    logic [31:0] rdata1_q, rdata2_q;
    logic [31:0] rd1, rd2;
    logic        rvalid_any;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        unique case (state_q)
            StArb: begin
                if (bus.req_b && wait_q == WaitMax) begin
                    gnt_b = 1'b1;
                end else if (bus.req_a) begin
                    gnt_a = 1'b1;
                end else if (bus.req_b) begin
                    gnt_b = 1'b1;
                end
                if (gnt_b && bus.lock_b && MAX_BURST > 1) begin
                    state_d = StBurst;
                    burst_d = BW'(1);
                end
            end
            StBurst: begin
                // A is stalled for the whole burst; the limiting beat is still granted.
                gnt_b = bus.req_b;
                if (gnt_b) begin
                    burst_d = burst_q + BW'(1);
                end
                if (!bus.lock_b || !bus.req_b || burst_d == BurstMax) begin
                    state_d = StArb;
                    burst_d = '0;
                end
            end
            default: state_d = StArb;
        endcase
        if (!bus.req_b || gnt_b) begin
            wait_d = '0;
        end else if (wait_q != WaitMax) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_comb begin
        sel_we  = 1'b0;
        sel_dr  = '0;
        sel_sr1 = '0;
        sel_sr2 = '0;
        sel_wd  = '0;
        if (gnt_a) begin
            sel_we  = bus.we_a;
            sel_dr  = bus.dr_a;
            sel_sr1 = bus.sr1_a;
            sel_sr2 = bus.sr2_a;
            sel_wd  = bus.wd_a;
        end else if (gnt_b) begin
            sel_we  = bus.we_b;
            sel_dr  = bus.dr_b;
            sel_sr1 = bus.sr1_b;
            sel_sr2 = bus.sr2_b;
            sel_wd  = bus.wd_b;
        end
        reg_w = sel_we && !(ZERO_R0 && sel_dr == '0);
    end

    // Register file returns the pre-write value on a same-cycle hit, so patch it here.
    always_comb begin
        rd1 = bus.ReadReg1;
        rd2 = bus.ReadReg2;
        if (fwd_we_q && fwd_sr1_q == fwd_dr_q) rd1 = fwd_wd_q;
        if (fwd_we_q && fwd_sr2_q == fwd_dr_q) rd2 = fwd_wd_q;
        if (ZERO_R0 && fwd_sr1_q == '0) rd1 = '0;
        if (ZERO_R0 && fwd_sr2_q == '0) rd2 = '0;
    end

    assign rvalid_any = rvalid_a_q | rvalid_b_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StArb;
            wait_q     <= '0;
            burst_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            fwd_we_q   <= 1'b0;
            fwd_dr_q   <= '0;
            fwd_sr1_q  <= '0;
            fwd_sr2_q  <= '0;
            fwd_wd_q   <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            burst_q    <= burst_d;
            rvalid_a_q <= gnt_a;
            rvalid_b_q <= gnt_b;
            if (gnt_a || gnt_b) begin
                fwd_we_q  <= reg_w;
                fwd_dr_q  <= sel_dr;
                fwd_sr1_q <= sel_sr1;
                fwd_sr2_q <= sel_sr2;
                fwd_wd_q  <= sel_wd;
            end
            if (rvalid_any) begin
                rdata1_q <= rd1;
                rdata2_q <= rd2;
            end
        end
    end

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.RegW     = reg_w;
    assign bus.DR       = sel_dr;
    assign bus.SR1      = sel_sr1;
    assign bus.SR2      = sel_sr2;
    assign bus.Reg_In   = sel_wd;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata1   = rvalid_any ? rd1 : rdata1_q;
    assign bus.rdata2   = rvalid_any ? rd2 : rdata2_q;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic
// against an architectural model of arbitration and register contents.
module tb_regfile_port_arbiter;
    localparam int unsigned MAX_WAIT  = 4;
    localparam int unsigned MAX_BURST = 8;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic rf_clear = 1'b1;
    always #5 CLK = ~CLK;

    regfile_port_arbiter_if bus ();

    regfile_port_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .MAX_BURST(MAX_BURST),
        .ZERO_R0  (1'b1)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    // Register file with registered reads that see the pre-write value.
    logic [31:0] rf [32];
    always_ff @(posedge CLK) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.RegW) begin
            rf[bus.DR] <= bus.Reg_In;
        end
        bus.ReadReg1 <= rf[bus.SR1];
        bus.ReadReg2 <= rf[bus.SR2];
    end

    typedef struct packed {
        logic        req_a;
        logic        we_a;
        logic [4:0]  dr_a;
        logic [4:0]  sr1_a;
        logic [4:0]  sr2_a;
        logic [31:0] wd_a;
        logic        req_b;
        logic        we_b;
        logic [4:0]  dr_b;
        logic [4:0]  sr1_b;
        logic [4:0]  sr2_b;
        logic [31:0] wd_b;
        logic        lock_b;
    } txn_t;

    typedef struct {
        txn_t        in;
        logic        ga;
        logic        gb;
        logic        regw;
        logic        va;
        logic        vb;
        logic [31:0] r1;
    } vec_t;

    int unsigned npass = 0;
    int unsigned ntotal = 0;

    // Architectural model state
    logic [31:0] arch [32];
    int unsigned starve;
    int unsigned beats;
    bit          in_burst;
    logic [31:0] last_r1, last_r2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        starve   = 0;
        beats    = 0;
        in_burst = 1'b0;
        last_r1  = '0;
        last_r2  = '0;
    endtask

    function automatic txn_t mk_a(input logic we, input logic [4:0] dr, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [31:0] wd);
        txn_t t;
        t = '0;
        t.req_a = 1'b1; t.we_a = we; t.dr_a = dr; t.sr1_a = s1; t.sr2_a = s2; t.wd_a = wd;
        return t;
    endfunction

    function automatic txn_t mk_b(input logic we, input logic [4:0] dr, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [31:0] wd, input logic lk);
        txn_t t;
        t = '0;
        t.req_b = 1'b1; t.we_b = we; t.dr_b = dr; t.sr1_b = s1; t.sr2_b = s2; t.wd_b = wd;
        t.lock_b = lk;
        return t;
    endfunction

    function automatic txn_t both(input txn_t a, input txn_t b);
        txn_t t;
        t = a;
        t.req_b = b.req_b; t.we_b = b.we_b; t.dr_b = b.dr_b; t.sr1_b = b.sr1_b;
        t.sr2_b = b.sr2_b; t.wd_b = b.wd_b; t.lock_b = b.lock_b;
        return t;
    endfunction

    task automatic apply(input txn_t t);
        bus.req_a = t.req_a; bus.we_a = t.we_a; bus.dr_a = t.dr_a;
        bus.sr1_a = t.sr1_a; bus.sr2_a = t.sr2_a; bus.wd_a = t.wd_a;
        bus.req_b = t.req_b; bus.we_b = t.we_b; bus.dr_b = t.dr_b;
        bus.sr1_b = t.sr1_b; bus.sr2_b = t.sr2_b; bus.wd_b = t.wd_b;
        bus.lock_b = t.lock_b;
    endtask

    // One transaction cycle, entered and left 1 time unit after a rising edge.
    task automatic run_cycle(input txn_t t, output logic o_ga, output logic o_gb,
                             output logic o_regw, output logic o_va, output logic o_vb,
                             output logic [31:0] o_r1);
        bit          ega, egb, ewe, wsel;
        logic [4:0]  edr, es1, es2;
        logic [31:0] ewd;
        apply(t);
        #1;
        ega = 1'b0;
        egb = 1'b0;
        if (in_burst) egb = t.req_b;
        else if (t.req_b && starve >= MAX_WAIT) egb = 1'b1;
        else if (t.req_a) ega = 1'b1;
        else if (t.req_b) egb = 1'b1;
        wsel = 1'b0; edr = '0; es1 = '0; es2 = '0; ewd = '0;
        if (ega) begin
            wsel = t.we_a; edr = t.dr_a; es1 = t.sr1_a; es2 = t.sr2_a; ewd = t.wd_a;
        end else if (egb) begin
            wsel = t.we_b; edr = t.dr_b; es1 = t.sr1_b; es2 = t.sr2_b; ewd = t.wd_b;
        end
        ewe = wsel && edr != 5'd0;
        check("gnt_a", 32'(bus.gnt_a), 32'(ega));
        check("gnt_b", 32'(bus.gnt_b), 32'(egb));
        check("gnt_excl", 32'(bus.gnt_a & bus.gnt_b), 32'd0);
        check("RegW", 32'(bus.RegW), 32'(ewe));
        check("DR", 32'(bus.DR), 32'(edr));
        check("SR1", 32'(bus.SR1), 32'(es1));
        check("SR2", 32'(bus.SR2), 32'(es2));
        check("Reg_In", bus.Reg_In, ewd);
        o_ga = bus.gnt_a; o_gb = bus.gnt_b; o_regw = bus.RegW;

        if (ewe) arch[edr] = ewd;
        if (ega || egb) begin
            last_r1 = (es1 == 5'd0) ? 32'd0 : arch[es1];
            last_r2 = (es2 == 5'd0) ? 32'd0 : arch[es2];
        end
        if (t.req_b && !egb) starve = (starve < MAX_WAIT) ? starve + 1 : starve;
        else starve = 0;
        if (in_burst) begin
            if (egb) beats++;
            if (!t.lock_b || !t.req_b || beats >= MAX_BURST) in_burst = 1'b0;
        end else if (egb && t.lock_b) begin
            in_burst = 1'b1;
            beats    = 1;
        end

        @(posedge CLK);
        #1;
        check("rvalid_a", 32'(bus.rvalid_a), 32'(ega));
        check("rvalid_b", 32'(bus.rvalid_b), 32'(egb));
        check("rdata1", bus.rdata1, last_r1);
        check("rdata2", bus.rdata2, last_r2);
        o_va = bus.rvalid_a; o_vb = bus.rvalid_b; o_r1 = bus.rdata1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        txn_t        idle, ab;
        logic        ga, gb, rw, va, vb;
        logic [31:0] r1;
        int unsigned nvb;

        idle = '0;
        apply(idle);
        for (int i = 0; i < 32; i++) arch[i] = '0;
        model_reset();

        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset rvalid_a", 32'(bus.rvalid_a), 32'd0);
        check("reset rvalid_b", 32'(bus.rvalid_b), 32'd0);
        check("reset rdata1", bus.rdata1, 32'd0);
        check("reset rdata2", bus.rdata2, 32'd0);
        RST_N    = 1'b1;
        rf_clear = 1'b0;
        @(posedge CLK);
        #1;

        // in, gnt_a, gnt_b, RegW, rvalid_a(next), rvalid_b(next), rdata1(next)
        vecs.push_back('{mk_a(1, 5, 0, 0, 32'hDEADBEEF), 1, 0, 1, 1, 0, 32'h0});
        vecs.push_back('{mk_a(0, 0, 5, 5, 32'h0), 1, 0, 0, 1, 0, 32'hDEADBEEF});
        vecs.push_back('{mk_a(1, 7, 7, 0, 32'h1234), 1, 0, 1, 1, 0, 32'h1234});
        vecs.push_back('{mk_a(1, 0, 0, 0, 32'hFFFFFFFF), 1, 0, 0, 1, 0, 32'h0});
        vecs.push_back('{mk_a(0, 0, 0, 7, 32'h0), 1, 0, 0, 1, 0, 32'h0});
        vecs.push_back('{mk_a(0, 0, 7, 0, 32'h0), 1, 0, 0, 1, 0, 32'h1234});
        vecs.push_back('{idle, 0, 0, 0, 0, 0, 32'h1234});
        vecs.push_back('{mk_b(1, 9, 9, 0, 32'h55, 0), 0, 1, 1, 0, 1, 32'h55});
        vecs.push_back('{both(mk_a(0, 0, 9, 0, 0), mk_b(0, 0, 5, 0, 0, 0)), 1, 0, 0, 1, 0,
                         32'h55});
        vecs.push_back('{idle, 0, 0, 0, 0, 0, 32'h55});

        foreach (vecs[i]) begin
            run_cycle(vecs[i].in, ga, gb, rw, va, vb, r1);
            check($sformatf("vec%0d gnt_a", i), 32'(ga), 32'(vecs[i].ga));
            check($sformatf("vec%0d gnt_b", i), 32'(gb), 32'(vecs[i].gb));
            check($sformatf("vec%0d RegW", i), 32'(rw), 32'(vecs[i].regw));
            check($sformatf("vec%0d rvalid_a", i), 32'(va), 32'(vecs[i].va));
            check($sformatf("vec%0d rvalid_b", i), 32'(vb), 32'(vecs[i].vb));
            check($sformatf("vec%0d rdata1", i), r1, vecs[i].r1);
        end

        // Continuous contention: B wins every fifth cycle.
        ab = both(mk_a(0, 0, 1, 2, 0), mk_b(0, 0, 3, 4, 0, 0));
        for (int i = 0; i < 15; i++) begin
            run_cycle(ab, ga, gb, rw, va, vb, r1);
            check($sformatf("starve%0d gnt_b", i), 32'(gb), 32'(i % 5 == 4));
        end

        // Locked burst against a requesting A: 4 A, 8 B, then A again.
        ab  = both(mk_a(0, 0, 5, 7, 0), mk_b(0, 0, 9, 5, 0, 1));
        nvb = 0;
        for (int i = 0; i < 13; i++) begin
            run_cycle(ab, ga, gb, rw, va, vb, r1);
            check($sformatf("burst%0d gnt_b", i), 32'(gb), 32'(i >= 4 && i <= 11));
            if (vb) nvb++;
        end
        check("burst rvalid_b pulses", nvb, 32'd8);
        run_cycle(idle, ga, gb, rw, va, vb, r1);

        // Reset asserted mid-burst, before the beat's response.
        run_cycle(mk_b(0, 0, 5, 0, 0, 1), ga, gb, rw, va, vb, r1);
        apply(mk_b(0, 0, 5, 0, 0, 1));
        #1;
        check("pre-reset burst gnt_b", 32'(bus.gnt_b), 32'd1);
        @(negedge CLK);
        RST_N = 1'b0;
        apply(idle);
        @(posedge CLK);
        #1;
        check("mid-reset rvalid_b", 32'(bus.rvalid_b), 32'd0);
        check("mid-reset rvalid_a", 32'(bus.rvalid_a), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("post-reset rdata1", bus.rdata1, 32'd0);
        check("post-reset rvalid_b", 32'(bus.rvalid_b), 32'd0);
        RST_N = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        run_cycle(both(mk_a(0, 0, 5, 0, 0), mk_b(0, 0, 9, 0, 0, 1)), ga, gb, rw, va, vb, r1);
        check("post-reset arb gnt_a", 32'(ga), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            txn_t t;
            t = '0;
            t.req_a  = ($urandom_range(0, 99) < 60);
            t.we_a   = 1'($urandom_range(0, 1));
            t.dr_a   = 5'($urandom_range(0, 7));
            t.sr1_a  = 5'($urandom_range(0, 7));
            t.sr2_a  = 5'($urandom_range(0, 7));
            t.wd_a   = $urandom;
            t.req_b  = ($urandom_range(0, 99) < 55);
            t.we_b   = 1'($urandom_range(0, 1));
            t.dr_b   = 5'($urandom_range(0, 7));
            t.sr1_b  = 5'($urandom_range(0, 7));
            t.sr2_b  = 5'($urandom_range(0, 7));
            t.wd_b   = $urandom;
            t.lock_b = ($urandom_range(0, 99) < 35);
            run_cycle(t, ga, gb, rw, va, vb, r1);
        end
        run_cycle(idle, ga, gb, rw, va, vb, r1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single-write, dual-read register file between two requesters: A (CPU pipeline, priority) and B (debug/loader port).
- One transaction is granted per clock, under fixed priority for A, with anti-starvation for B and an optional locked burst for B.
- Drives the register file's RegW/DR/SR1/SR2/Reg_In. Returns read data one cycle after grant, with write-first forwarding and r0 protection.

Parameters:
- MAX_WAIT, 4: consecutive cycles B may be denied while requesting before B takes priority for one grant.
- MAX_BURST, 8: maximum consecutive locked grants to B before forced release.
- ZERO_R0, 1: when 1, writes to register 0 are suppressed and reads of register 0 return 0.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- req_a  in  1  A transaction request.
- we_a  in  1  A write enable.
- dr_a  in  5  A destination register.
- sr1_a  in  5  A source register 1.
- sr2_a  in  5  A source register 2.
- wd_a  in  32  A write data.
- gnt_a  out  1  A granted this cycle (combinational).
- req_b, we_b, dr_b, sr1_b, sr2_b, wd_b  in  1/1/5/5/5/32  B transaction fields, same meaning as A.
- lock_b  in  1  B requests that the grant be held for a burst.
- gnt_b  out  1  B granted this cycle (combinational).
- RegW  out  1  register file write enable.
- DR  out  5  register file destination.
- SR1  out  5  register file source 1.
- SR2  out  5  register file source 2.
- Reg_In  out  32  register file write data.
- ReadReg1  in  32  register file read data 1 (registered in the register file).
- ReadReg2  in  32  register file read data 2 (registered in the register file).
- rvalid_a  out  1  read response for A.
- rvalid_b  out  1  read response for B.
- rdata1  out  32  response data 1.
- rdata2  out  32  response data 2.

Behaviour:
- Reset (async, RST_N=0):
  - state=ARB, wait_cnt=0, burst_cnt=0.
  - rvalid_a=rvalid_b=0, rdata1=rdata2=0.
  - Forwarding registers cleared.
  - A response pending at reset is dropped.
- gnt_a and gnt_b are mutually exclusive and are never asserted without the matching req.
- State ARB:
  - If req_b and wait_cnt==MAX_WAIT: gnt_b.
  - Else if req_a: gnt_a.
  - Else if req_b: gnt_b.
  - wait_cnt increments (saturating at MAX_WAIT) on each cycle req_b=1 and gnt_b=0. It clears on gnt_b or when req_b=0.
  - gnt_b with lock_b=1 moves to state BURST with burst_cnt=1.
- State BURST:
  - gnt_b=req_b and gnt_a=0; A stalls even when requesting.
  - Each granted beat increments burst_cnt.
  - Return to ARB when lock_b=0, req_b=0, or the granted beat makes burst_cnt==MAX_BURST. That beat is the last B grant; A has priority on the next cycle if requesting.
- Register file drive:
  - DR/SR1/SR2/Reg_In are muxed from the granted requester and are all 0 when idle.
  - RegW = granted & we & !(ZERO_R0 && dr==0).
- Response timing:
  - rvalid_x is registered and goes high exactly one cycle after gnt_x, for every grant (writes included).
  - rdata is driven only while an rvalid is high; it holds its value otherwise.
- Forwarding:
  - The register file samples the old value when read and write hit the same register in one cycle.
  - The arbiter registers (we_eff, dr, wd, sr1, sr2) at grant.
  - If we_eff and sr1==dr, rdata1=wd; else rdata1=ReadReg1. rdata2 follows the same rule with sr2. This gives write-first semantics.
- r0 handling: with ZERO_R0=1, a source of 0 returns 0, overriding forwarding.
- Back-to-back grants are allowed every cycle, and throughput is one transaction per cycle.

Test Plan:
1. After reset, A writes r5=0xDEADBEEF, then A reads sr1=5 → rvalid_a one cycle after the second grant, rdata1=0xDEADBEEF.
2. A with we=1, dr=7, wd=0x1234 and sr1=7 in the same transaction → rdata1=0x1234 (forwarded), not the old value 0.
3. req_a and req_b both held high continuously (MAX_WAIT=4) → grants A,A,A,A,B,A,A,A,A,B…; no cycle has both grants.
4. B locks with lock_b=1 and req_a=1 throughout (MAX_BURST=8) → exactly 8 consecutive gnt_b, then gnt_a; rvalid_b pulses 8 times.
5. Write r0=0xFFFFFFFF, then read r0 → RegW=0 during the write grant; rdata1=0.
6. Assert RST_N=0 the cycle after a grant → rvalid stays 0 and the FSM is in ARB on release.
